// File: rtl/lsu_pkg.sv
// Shared types and constants for the load-store unit: load selects, store lane masks,
// default address map and the access-size alignment helper.
package lsu_pkg;

    typedef enum logic [2:0] {
        LB      = 3'b000,
        LH      = 3'b001,
        LW      = 3'b010,
        LBU     = 3'b011,
        LHU     = 3'b100,
        LD_NONE = 3'b111
    } ld_sel_e;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2
    } acc_size_e;

    localparam int          DEF_DMEM_WORDS = 2048;
    localparam logic [31:0] DEF_DMEM_BASE  = 32'h0000_2000;
    localparam logic [31:0] DEF_LEDR_ADDR  = 32'h0000_7000;
    localparam logic [31:0] DEF_LEDG_ADDR  = 32'h0000_7010;
    localparam logic [31:0] DEF_SW_ADDR    = 32'h0000_7800;

    localparam logic [3:0] BM_B = 4'b0001;
    localparam logic [3:0] BM_H = 4'b0011;
    localparam logic [3:0] BM_W = 4'b1111;

    function automatic logic is_misaligned(acc_size_e size, logic [1:0] offset);
        case (size)
            SZ_H:    return offset[0];
            SZ_W:    return offset != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_dmem_array.sv
// Flop-based data memory: asynchronous read, byte-lane write on the rising edge.
// Contents are deliberately not reset so a core reset keeps program data.
module dmem_array #(
    parameter int WORDS = 2048,
    parameter int AW    = 11
) (
    input  logic          clk,
    input  logic [AW-1:0] addr,
    input  logic [3:0]    we,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);

    logic [31:0] mem [WORDS];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) begin
                mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/lsu.sv
// Load-store unit: region decode, alignment check, byte-lane stores, extended loads,
// memory-mapped LED registers and a two-flop switch synchroniser.
module lsu #(
    parameter int          DMEM_WORDS = lsu_pkg::DEF_DMEM_WORDS,
    parameter logic [31:0] DMEM_BASE  = lsu_pkg::DEF_DMEM_BASE,
    parameter logic [31:0] LEDR_ADDR  = lsu_pkg::DEF_LEDR_ADDR,
    parameter logic [31:0] LEDG_ADDR  = lsu_pkg::DEF_LEDG_ADDR,
    parameter logic [31:0] SW_ADDR    = lsu_pkg::DEF_SW_ADDR
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] addr,
    input  logic [31:0] st_data,
    input  logic        wr_en,
    input  logic [3:0]  bmask,
    input  logic [2:0]  ld_sel,
    input  logic [31:0] io_sw,
    output logic [31:0] ld_data,
    output logic [31:0] io_ledr,
    output logic [31:0] io_ledg,
    output logic        misalign
);

    import lsu_pkg::*;

    localparam int          AW       = $clog2(DMEM_WORDS);
    localparam logic [31:0] DMEM_END = DMEM_BASE + 32'(4 * DMEM_WORDS);

    logic [1:0]    offset;
    logic          in_dmem;
    logic          hit_ledr;
    logic          hit_ledg;
    logic          hit_sw;
    acc_size_e     st_size;
    acc_size_e     ld_size;
    logic          st_mis;
    logic          ld_mis;
    logic          st_ok;
    logic [3:0]    lane;
    logic [31:0]   wdata;
    logic [3:0]    dmem_we;
    logic [AW-1:0] dmem_idx;
    logic [31:0]   dmem_rdata;
    logic [31:0]   sw_meta;
    logic [31:0]   sw_sync;
    logic [31:0]   rd_word;
    logic [31:0]   rd_shift;

    assign offset   = addr[1:0];
    assign in_dmem  = (addr >= DMEM_BASE) && (addr < DMEM_END);
    assign hit_ledr = addr[31:2] == LEDR_ADDR[31:2];
    assign hit_ledg = addr[31:2] == LEDG_ADDR[31:2];
    assign hit_sw   = addr[31:2] == SW_ADDR[31:2];

    always_comb begin
        case (bmask)
            BM_W:    st_size = SZ_W;
            BM_H:    st_size = SZ_H;
            default: st_size = SZ_B;
        endcase
    end

    always_comb begin
        case (ld_sel)
            LH, LHU: ld_size = SZ_H;
            LW:      ld_size = SZ_W;
            default: ld_size = SZ_B;
        endcase
    end

    assign st_mis   = is_misaligned(st_size, offset);
    assign ld_mis   = is_misaligned(ld_size, offset);
    assign misalign = wr_en ? st_mis : ld_mis;

    assign st_ok = wr_en && !st_mis;
    assign lane  = bmask << offset;
    assign wdata = st_data << {offset, 3'b000};

    assign dmem_we  = (st_ok && in_dmem) ? lane : 4'b0000;
    assign dmem_idx = AW'((addr - DMEM_BASE) >> 2);

    dmem_array #(
        .WORDS (DMEM_WORDS),
        .AW    (AW)
    ) u_dmem (
        .clk   (clk),
        .addr  (dmem_idx),
        .we    (dmem_we),
        .wdata (wdata),
        .rdata (dmem_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            io_ledr <= '0;
            io_ledg <= '0;
            sw_meta <= '0;
            sw_sync <= '0;
        end else begin
            sw_meta <= io_sw;
            sw_sync <= sw_meta;
            for (int i = 0; i < 4; i++) begin
                if (st_ok && hit_ledr && lane[i]) begin
                    io_ledr[8*i +: 8] <= wdata[8*i +: 8];
                end
                if (st_ok && hit_ledg && lane[i]) begin
                    io_ledg[8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    // Load path reads pre-edge storage, so a same-cycle store is not visible yet.
    always_comb begin
        rd_word = '0;
        if (in_dmem) begin
            rd_word = dmem_rdata;
        end else if (hit_ledr) begin
            rd_word = io_ledr;
        end else if (hit_ledg) begin
            rd_word = io_ledg;
        end else if (hit_sw) begin
            rd_word = sw_sync;
        end
    end

    assign rd_shift = rd_word >> {offset, 3'b000};

    always_comb begin
        ld_data = '0;
        if (!ld_mis) begin
            case (ld_sel)
                LB:      ld_data = {{24{rd_shift[7]}}, rd_shift[7:0]};
                LH:      ld_data = {{16{rd_shift[15]}}, rd_shift[15:0]};
                LW:      ld_data = rd_word;
                LBU:     ld_data = {24'h0, rd_shift[7:0]};
                LHU:     ld_data = {16'h0, rd_shift[15:0]};
                default: ld_data = '0;
            endcase
        end
    end

endmodule

// File: tb/tb_lsu.sv
// Self-checking bench for lsu: directed vector table, reset/synchroniser sequences,
// and randomized traffic against a byte-addressed reference model.
module tb_lsu;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] addr;
    logic [31:0] st_data;
    logic        wr_en;
    logic [3:0]  bmask;
    logic [2:0]  ld_sel;
    logic [31:0] io_sw;
    logic [31:0] ld_data;
    logic [31:0] io_ledr;
    logic [31:0] io_ledg;
    logic        misalign;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lsu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .addr     (addr),
        .st_data  (st_data),
        .wr_en    (wr_en),
        .bmask    (bmask),
        .ld_sel   (ld_sel),
        .io_sw    (io_sw),
        .ld_data  (ld_data),
        .io_ledr  (io_ledr),
        .io_ledg  (io_ledg),
        .misalign (misalign)
    );

    typedef struct {
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  bm;
        logic [2:0]  ld;
        logic [31:0] exp_ld;
        logic        exp_mis;
        string       name;
    } vec_t;

    vec_t vecs[$];

    // Reference state: one byte per mapped writable address, plus switch history since reset.
    logic [7:0]  mdl [logic [31:0]];
    logic [31:0] sw_hist[$];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) sw_hist.delete();
        else        sw_hist.push_back(io_sw);
    end

    function automatic logic [31:0] sw_vis();
        if (sw_hist.size() < 2) return 32'h0;
        return sw_hist[sw_hist.size() - 2];
    endfunction

    function automatic bit writable(logic [31:0] a);
        return (a >= 32'h2000 && a < 32'h4000) ||
               (a >= 32'h7000 && a < 32'h7004) ||
               (a >= 32'h7010 && a < 32'h7014);
    endfunction

    function automatic bit is_sw(logic [31:0] a);
        return a >= 32'h7800 && a < 32'h7804;
    endfunction

    function automatic int bm_size(logic [3:0] bm);
        if (bm == 4'b1111) return 4;
        if (bm == 4'b0011) return 2;
        return 1;
    endfunction

    function automatic int ld_size(logic [2:0] ld);
        case (ld)
            3'b000, 3'b011: return 1;
            3'b001, 3'b100: return 2;
            3'b010:         return 4;
            default:        return 0;
        endcase
    endfunction

    function automatic logic model_mis(logic wr, logic [31:0] a, logic [3:0] bm, logic [2:0] ld);
        int sz;
        sz = wr ? bm_size(bm) : ld_size(ld);
        return (sz != 0) && ((a % sz) != 0);
    endfunction

    function automatic void model_store(logic [31:0] a, logic [31:0] d, logic [3:0] bm);
        int sz;
        sz = bm_size(bm);
        if ((a % sz) == 0 && writable(a)) begin
            for (int k = 0; k < sz; k++) mdl[a + k] = d[8*k +: 8];
        end
    endfunction

    function automatic logic [31:0] model_load(logic [31:0] a, logic [2:0] ld);
        int          sz;
        logic [31:0] v;
        logic [31:0] w;
        sz = ld_size(ld);
        v  = 32'h0;
        if (sz == 0 || (a % sz) != 0) return 32'h0;
        if (is_sw(a)) begin
            w = sw_vis();
            v = w >> (8 * (a % 4));
        end else if (writable(a)) begin
            for (int k = 0; k < sz; k++) v[8*k +: 8] = mdl.exists(a + k) ? mdl[a + k] : 8'h00;
        end else begin
            return 32'h0;
        end
        case (ld)
            3'b000:  return {{24{v[7]}}, v[7:0]};
            3'b001:  return {{16{v[15]}}, v[15:0]};
            3'b011:  return {24'h0, v[7:0]};
            3'b100:  return {16'h0, v[15:0]};
            default: return v;
        endcase
    endfunction

    function automatic logic [31:0] model_word(logic [31:0] a);
        logic [31:0] w;
        for (int k = 0; k < 4; k++) w[8*k +: 8] = mdl.exists(a + k) ? mdl[a + k] : 8'h00;
        return w;
    endfunction

    task automatic check32(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] bm, logic [2:0] ld);
        wr_en   = wr;
        addr    = a;
        st_data = d;
        bmask   = bm;
        ld_sel  = ld;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        @(negedge clk);
        rst_n = 1'b1;
        step();
    endtask

    function automatic vec_t v(logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] bm,
                               logic [2:0] ld, logic [31:0] e, logic m, string n);
        vec_t r;
        r.wr = wr; r.a = a; r.d = d; r.bm = bm; r.ld = ld;
        r.exp_ld = e; r.exp_mis = m; r.name = n;
        return r;
    endfunction

    // Randomized op checked against the model, then the model absorbs any store.
    task automatic do_op(logic wr, logic [31:0] a, logic [31:0] d, logic [3:0] bm, logic [2:0] ld);
        drive(wr, a, d, bm, ld);
        @(negedge clk);
        check32($sformatf("rnd_ld a=%08h ld=%0d", a, ld), ld_data, wr ? 32'h0 : model_load(a, ld));
        check32($sformatf("rnd_mis a=%08h", a), {31'h0, misalign}, {31'h0, model_mis(wr, a, bm, ld)});
        check32("rnd_ledr", io_ledr, model_word(32'h7000));
        check32("rnd_ledg", io_ledg, model_word(32'h7010));
        if (wr) model_store(a, d, bm);
        step();
    endtask

    initial begin
        logic [3:0]  bm_pick [3];
        logic [31:0] ra;
        logic        rw;
        bm_pick[0] = 4'b0001;
        bm_pick[1] = 4'b0011;
        bm_pick[2] = 4'b1111;

        io_sw = 32'h0;
        drive(1'b0, 32'h0, 32'h0, 4'b0000, 3'b111);
        do_reset();

        check32("reset_ledr", io_ledr, 32'h0);
        check32("reset_ledg", io_ledg, 32'h0);
        drive(1'b0, 32'h7800, 32'h0, 4'b0000, 3'b010);
        #1;
        check32("reset_sw", ld_data, 32'h0);

        vecs.push_back(v(1, 32'h2000, 32'hDEADBEEF, 4'b1111, 3'b111, 32'h0,        0, "sw_2000"));
        vecs.push_back(v(0, 32'h2003, 32'h0,        4'b0000, 3'b000, 32'hFFFFFFDE, 0, "lb_2003"));
        vecs.push_back(v(0, 32'h2003, 32'h0,        4'b0000, 3'b011, 32'h000000DE, 0, "lbu_2003"));
        vecs.push_back(v(0, 32'h2002, 32'h0,        4'b0000, 3'b001, 32'hFFFFDEAD, 0, "lh_2002"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b100, 32'h0000BEEF, 0, "lhu_2000"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b010, 32'hDEADBEEF, 0, "lw_2000"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b000, 32'hFFFFFFEF, 0, "lb_2000"));
        vecs.push_back(v(0, 32'h2001, 32'h0,        4'b0000, 3'b011, 32'h000000BE, 0, "lbu_2001"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b001, 32'hFFFFBEEF, 0, "lh_2000"));
        vecs.push_back(v(1, 32'h2004, 32'h11223344, 4'b1111, 3'b111, 32'h0,        0, "sw_2004"));
        vecs.push_back(v(1, 32'h2005, 32'h000000AA, 4'b0001, 3'b111, 32'h0,        0, "sb_2005"));
        vecs.push_back(v(1, 32'h2006, 32'h0000BEEF, 4'b0011, 3'b111, 32'h0,        0, "sh_2006"));
        vecs.push_back(v(0, 32'h2004, 32'h0,        4'b0000, 3'b010, 32'hBEEFAA44, 0, "lw_2004_merge"));
        vecs.push_back(v(1, 32'h2001, 32'hFFFFFFFF, 4'b0011, 3'b111, 32'h0,        1, "sh_mis_2001"));
        vecs.push_back(v(1, 32'h2002, 32'hFFFFFFFF, 4'b1111, 3'b111, 32'h0,        1, "sw_mis_2002"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b010, 32'hDEADBEEF, 0, "lw_2000_kept"));
        vecs.push_back(v(0, 32'h2002, 32'h0,        4'b0000, 3'b010, 32'h0,        1, "lw_mis_2002"));
        vecs.push_back(v(0, 32'h2003, 32'h0,        4'b0000, 3'b001, 32'h0,        1, "lh_mis_2003"));
        vecs.push_back(v(0, 32'h2001, 32'h0,        4'b0000, 3'b100, 32'h0,        1, "lhu_mis_2001"));
        vecs.push_back(v(0, 32'h2001, 32'h0,        4'b0000, 3'b000, 32'hFFFFFFBE, 0, "lb_2001"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b101, 32'h0,        0, "ld_101"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b110, 32'h0,        0, "ld_110"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b111, 32'h0,        0, "ld_none"));
        vecs.push_back(v(1, 32'h7000, 32'h000000FF, 4'b1111, 3'b111, 32'h0,        0, "sw_ledr"));
        vecs.push_back(v(0, 32'h7000, 32'h0,        4'b0000, 3'b010, 32'h000000FF, 0, "lw_ledr"));
        vecs.push_back(v(0, 32'h7010, 32'h0,        4'b0000, 3'b010, 32'h0,        0, "lw_ledg_0"));
        vecs.push_back(v(1, 32'h7010, 32'h12345678, 4'b1111, 3'b111, 32'h0,        0, "sw_ledg"));
        vecs.push_back(v(0, 32'h7012, 32'h0,        4'b0000, 3'b001, 32'h00001234, 0, "lh_ledg_hi"));
        vecs.push_back(v(1, 32'h7800, 32'hFFFFFFFF, 4'b1111, 3'b111, 32'h0,        0, "sw_to_sw"));
        vecs.push_back(v(0, 32'h7800, 32'h0,        4'b0000, 3'b010, 32'h0,        0, "lw_sw_ro"));
        vecs.push_back(v(1, 32'h1000, 32'hFFFFFFFF, 4'b1111, 3'b111, 32'h0,        0, "sw_unmapped"));
        vecs.push_back(v(0, 32'h1000, 32'h0,        4'b0000, 3'b010, 32'h0,        0, "lw_unmapped"));
        vecs.push_back(v(0, 32'h2000, 32'h0,        4'b0000, 3'b010, 32'hDEADBEEF, 0, "lw_2000_after_unm"));
        vecs.push_back(v(1, 32'h3FFC, 32'hCAFEF00D, 4'b1111, 3'b111, 32'h0,        0, "sw_top"));
        vecs.push_back(v(0, 32'h3FFC, 32'h0,        4'b0000, 3'b010, 32'hCAFEF00D, 0, "lw_top"));
        vecs.push_back(v(1, 32'h4000, 32'h55555555, 4'b1111, 3'b111, 32'h0,        0, "sw_past_end"));
        vecs.push_back(v(0, 32'h4000, 32'h0,        4'b0000, 3'b010, 32'h0,        0, "lw_past_end"));
        vecs.push_back(v(0, 32'h1FFC, 32'h0,        4'b0000, 3'b010, 32'h0,        0, "lw_below_base"));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].bm, vecs[i].ld);
            @(negedge clk);
            if (!vecs[i].wr) check32({vecs[i].name, "_ld"}, ld_data, vecs[i].exp_ld);
            check32({vecs[i].name, "_mis"}, {31'h0, misalign}, {31'h0, vecs[i].exp_mis});
            step();
        end

        check32("ledr_after_table", io_ledr, 32'h000000FF);
        check32("ledg_after_table", io_ledg, 32'h12345678);

        // Mid-cycle reset clears the LEDs at once; DMEM contents survive.
        drive(1'b0, 32'h2000, 32'h0, 4'b0000, 3'b010);
        #2;
        rst_n = 1'b0;
        #1;
        check32("async_rst_ledr", io_ledr, 32'h0);
        check32("async_rst_ledg", io_ledg, 32'h0);
        check32("dmem_kept_in_rst", ld_data, 32'hDEADBEEF);

        io_sw = 32'h5A5A5A5A;
        drive(1'b0, 32'h7800, 32'h0, 4'b0000, 3'b010);
        step();
        check32("sw_held_in_rst", ld_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        check32("sw_after_1_edge", ld_data, 32'h0);
        step();
        check32("sw_after_2_edges", ld_data, 32'h5A5A5A5A);
        drive(1'b1, 32'h7800, 32'hFFFFFFFF, 4'b1111, 3'b111);
        step();
        drive(1'b0, 32'h7800, 32'h0, 4'b0000, 3'b010);
        #1;
        check32("sw_store_ignored", ld_data, 32'h5A5A5A5A);
        check32("ledr_still_clear", io_ledr, 32'h0);

        // Randomized traffic from a clean reset with known contents in the hot windows.
        drive(1'b0, 32'h0, 32'h0, 4'b0000, 3'b111);
        do_reset();
        mdl.delete();
        for (int k = 0; k < 4; k++) begin
            mdl[32'h7000 + k] = 8'h00;
            mdl[32'h7010 + k] = 8'h00;
        end
        for (int w = 0; w < 16; w++) begin
            do_op(1'b1, 32'h2000 + 32'(4 * w), $urandom, 4'b1111, 3'b111);
            do_op(1'b1, 32'h3FC0 + 32'(4 * w), $urandom, 4'b1111, 3'b111);
        end

        for (int it = 0; it < 600; it++) begin
            if (it % 32 == 0) io_sw = $urandom;
            case ($urandom_range(0, 7))
                0, 1:    ra = 32'h2000 + 32'($urandom_range(0, 63));
                2:       ra = 32'h3FC0 + 32'($urandom_range(0, 63));
                3:       ra = 32'h4000 + 32'($urandom_range(0, 7));
                4:       ra = 32'h1FF8 + 32'($urandom_range(0, 7));
                5:       ra = 32'h7000 + 32'($urandom_range(0, 3));
                6:       ra = 32'h7010 + 32'($urandom_range(0, 3));
                default: ra = 32'h7800 + 32'($urandom_range(0, 3));
            endcase
            rw = ($urandom_range(0, 2) == 0);
            if (rw) do_op(1'b1, ra, $urandom, bm_pick[$urandom_range(0, 2)], 3'b111);
            else    do_op(1'b0, ra, 32'h0, 4'b0000, 3'($urandom_range(0, 7)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
